// File: rtl/lcd_bus_monitor.sv
// HD44780-side monitor for the 4-bit LCD bus.
// Decodes nibbles into commands/chars and mirrors the 80-byte DDRAM.
module lcd_bus_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 4095
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rs_in,
  input  logic       enable_in,
  input  logic [3:0] data_in,
  input  logic [6:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       cmd_valid,
  output logic       char_valid,
  output logic [7:0] byte_out,
  output logic [6:0] addr_counter,
  output logic       mode_4bit,
  output logic       two_line,
  output logic       display_on,
  output logic       busy,
  output logic       protocol_err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    MODE8,
    HI,
    LO
  } rx_t;

  rx_t rx, rx_nx;

  logic [SYNC_STAGES:0] e_p;
  logic [SYNC_STAGES:0] r_p;
  logic [3:0]           d_p [0:SYNC_STAGES];

  logic          edge_det;
  logic          nrs;
  logic [3:0]    nib;
  logic [3:0]    hi_nib;
  logic          hi_rs;
  logic [TW-1:0] tmo_cnt;
  logic          incr;
  logic [6:0]    fill_idx;

  logic          hi_load;
  logic          byte_done;
  logic          byte_rs;
  logic [7:0]    byte_val;
  logic          rx_err;
  logic          is_fset;
  logic          ac_ok;
  logic [6:0]    ac_idx;
  logic [6:0]    ac_step;
  logic          char_we;

  logic [7:0]    mem [0:79];

  always_ff @(posedge clk) begin
    if (rst) begin
      e_p <= '0;
      r_p <= '0;
      d_p <= '{default: '0};
    end else begin
      e_p <= {e_p[SYNC_STAGES-1:0], enable_in};
      r_p <= {r_p[SYNC_STAGES-1:0], rs_in};
      d_p[0] <= data_in;
      for (int i = 1; i <= SYNC_STAGES; i++)
        d_p[i] <= d_p[i-1];
    end
  end

  // rs/data come from the same stage that still saw E high
  assign edge_det = e_p[SYNC_STAGES] & ~e_p[SYNC_STAGES-1];
  assign nib      = d_p[SYNC_STAGES];
  assign nrs      = r_p[SYNC_STAGES];

  always_ff @(posedge clk) begin
    if (rst) rx <= MODE8;
    else     rx <= rx_nx;
  end

  always_comb begin
    rx_nx     = rx;
    hi_load   = 1'b0;
    byte_done = 1'b0;
    byte_rs   = 1'b0;
    byte_val  = 8'h00;
    rx_err    = 1'b0;
    is_fset   = 1'b0;
    unique case (rx)
      MODE8: begin
        if (edge_det) begin
          byte_done = 1'b1;
          byte_val  = {nib, 4'h0};
        end
      end
      HI: begin
        if (edge_det) begin
          hi_load = 1'b1;
          rx_nx   = LO;
        end
      end
      LO: begin
        if (edge_det) begin
          rx_nx = HI;
          if (nrs != hi_rs) begin
            rx_err = 1'b1;
          end else begin
            byte_done = 1'b1;
            byte_rs   = hi_rs;
            byte_val  = {hi_nib, nib};
          end
        end else if (tmo_cnt == TW'(TIMEOUT)) begin
          rx_nx  = HI;
          rx_err = 1'b1;
        end
      end
      default: rx_nx = MODE8;
    endcase
    is_fset = byte_done & ~busy & ~byte_rs
            & (byte_val[7:5] == 3'b001);
    if (is_fset)
      rx_nx = byte_val[4] ? MODE8 : HI;
  end

  always_comb begin
    ac_ok   = 1'b0;
    ac_idx  = addr_counter;
    ac_step = addr_counter;
    if (two_line) begin
      ac_ok  = addr_counter[5:0] <= 6'd39;
      ac_idx = {1'b0, addr_counter[5:0]}
             + (addr_counter[6] ? 7'd40 : 7'd0);
      if (incr) begin
        unique case (1'b1)
          addr_counter == 7'h27: ac_step = 7'h40;
          addr_counter == 7'h67: ac_step = 7'h00;
          default:               ac_step = addr_counter + 7'd1;
        endcase
      end else begin
        unique case (1'b1)
          addr_counter == 7'h40: ac_step = 7'h27;
          addr_counter == 7'h00: ac_step = 7'h67;
          default:               ac_step = addr_counter - 7'd1;
        endcase
      end
    end else begin
      ac_ok = addr_counter <= 7'd79;
      if (incr)
        ac_step = (addr_counter == 7'h4F) ? 7'h00
                                          : addr_counter + 7'd1;
      else
        ac_step = (addr_counter == 7'h00) ? 7'h4F
                                          : addr_counter - 7'd1;
    end
  end

  assign char_we = byte_done & ~busy & byte_rs & ac_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_nib       <= 4'h0;
      hi_rs        <= 1'b0;
      tmo_cnt      <= '0;
      incr         <= 1'b1;
      fill_idx     <= 7'd0;
      busy         <= 1'b1;
      cmd_valid    <= 1'b0;
      char_valid   <= 1'b0;
      byte_out     <= 8'h00;
      addr_counter <= 7'h00;
      mode_4bit    <= 1'b0;
      two_line     <= 1'b0;
      display_on   <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      cmd_valid  <= 1'b0;
      char_valid <= 1'b0;
      if (rx_err) protocol_err <= 1'b1;
      if (hi_load) begin
        hi_nib  <= nib;
        hi_rs   <= nrs;
        tmo_cnt <= '0;
      end else if (rx == LO && tmo_cnt != TW'(TIMEOUT)) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      if (busy) begin
        fill_idx <= fill_idx + 7'd1;
        if (fill_idx == 7'd79) busy <= 1'b0;
      end
      if (byte_done) begin
        if (busy) begin
          protocol_err <= 1'b1;
        end else if (byte_rs) begin
          if (ac_ok) begin
            char_valid   <= 1'b1;
            byte_out     <= byte_val;
            addr_counter <= ac_step;
          end else begin
            protocol_err <= 1'b1;
          end
        end else begin
          cmd_valid <= 1'b1;
          byte_out  <= byte_val;
          unique case (1'b1)
            byte_val[7]: addr_counter <= byte_val[6:0];
            byte_val[7:5] == 3'b001: begin
              two_line  <= byte_val[3];
              mode_4bit <= ~byte_val[4];
            end
            byte_val[7:3] == 5'b00001: display_on <= byte_val[2];
            byte_val[7:2] == 6'b000001: incr <= byte_val[1];
            byte_val[7:1] == 7'b0000001: addr_counter <= 7'h00;
            byte_val == 8'h01: begin
              addr_counter <= 7'h00;
              incr         <= 1'b1;
              busy         <= 1'b1;
              fill_idx     <= 7'd0;
            end
            default: ;
          endcase
        end
      end
    end
  end

  // fill and char writes never collide: chars are dropped while busy
  always_ff @(posedge clk) begin
    if (busy)         mem[fill_idx] <= 8'h20;
    else if (char_we) mem[ac_idx]   <= byte_val;
    rd_data <= (rd_addr < 7'd80) ? mem[rd_addr] : 8'h20;
  end

endmodule

// File: tb/tb_lcd_bus_monitor.sv
// Bench for lcd_bus_monitor: drives the LCD pins and checks
// strobes, controller state and DDRAM against a linear-address model.
module tb_lcd_bus_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic       rs_in;
  logic       enable_in;
  logic [3:0] data_in;
  logic [6:0] rd_addr;
  logic [7:0] rd_data;
  logic       cmd_valid;
  logic       char_valid;
  logic [7:0] byte_out;
  logic [6:0] addr_counter;
  logic       mode_4bit;
  logic       two_line;
  logic       display_on;
  logic       busy;
  logic       protocol_err;

  lcd_bus_monitor #(.SYNC_STAGES(2), .TIMEOUT(4095)) dut (
    .clk(clk), .rst(rst), .rs_in(rs_in), .enable_in(enable_in),
    .data_in(data_in), .rd_addr(rd_addr), .rd_data(rd_data),
    .cmd_valid(cmd_valid), .char_valid(char_valid),
    .byte_out(byte_out), .addr_counter(addr_counter),
    .mode_4bit(mode_4bit), .two_line(two_line),
    .display_on(display_on), .busy(busy),
    .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", n, act, exp);
    end
  endtask

  // model: DDRAM as 80 linear cells, AC mapped to/from a linear slot
  bit         m_mode4, m_two, m_disp, m_inc, m_err;
  int         m_ac;
  logic [7:0] m_mem [80];
  logic [8:0] expq [$];

  function automatic int lin(input int ac);
    if (!m_two) return (ac < 80) ? ac : -1;
    if (ac <= 39) return ac;
    if (ac >= 64 && ac <= 103) return ac - 64 + 40;
    return -1;
  endfunction

  function automatic int unlin(input int p);
    if (!m_two) return p;
    return (p < 40) ? p : p - 40 + 64;
  endfunction

  task automatic m_reset();
    m_mode4 = 0; m_two = 0; m_disp = 0; m_inc = 1; m_err = 0;
    m_ac = 0;
    for (int i = 0; i < 80; i++) m_mem[i] = 8'h20;
    expq.delete();
  endtask

  task automatic m_apply(input bit rs, input logic [7:0] b);
    int p;
    if (rs) begin
      p = lin(m_ac);
      if (p < 0) begin
        m_err = 1;
      end else begin
        m_mem[p] = b;
        expq.push_back({1'b1, b});
        m_ac = unlin((p + (m_inc ? 1 : 79)) % 80);
      end
    end else begin
      expq.push_back({1'b0, b});
      if (b == 8'h01) begin
        for (int i = 0; i < 80; i++) m_mem[i] = 8'h20;
        m_ac = 0; m_inc = 1;
      end else if (b[7:1] == 7'h01) m_ac = 0;
      else if (b[7:2] == 6'h01) m_inc = b[1];
      else if (b[7:3] == 5'h01) m_disp = b[2];
      else if (b[7:5] == 3'h1) begin
        m_two = b[3]; m_mode4 = !b[4];
      end else if (b[7]) m_ac = int'(b[6:0]);
    end
  endtask

  // compare process: every strobe against the model, plus fill length
  int busy_run = 0;
  always @(negedge clk) begin
    logic [8:0] e;
    if (rst) begin
      busy_run = 0;
    end else begin
      if (busy) busy_run++;
      else if (busy_run != 0) begin
        chk("busy_len", busy_run, 80);
        busy_run = 0;
      end
      if (cmd_valid || char_valid) begin
        if (expq.size() == 0) begin
          checks++; errors++;
          $display("FAIL strobe: got cmd=%0b char=%0b byte %02h, expected none",
                   cmd_valid, char_valid, byte_out);
        end else begin
          e = expq.pop_front();
          chk("strobe_kind", {char_valid, cmd_valid},
              e[8] ? 32'd2 : 32'd1);
          chk("byte_out", byte_out, e[7:0]);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic nib(input bit rs, input logic [3:0] d);
    @(posedge clk); #1;
    rs_in = rs; data_in = d; enable_in = 1'b1;
    repeat (4) @(posedge clk);
    #1 enable_in = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic send_raw(input bit rs, input logic [7:0] b, input bit four);
    if (four) begin
      nib(rs, b[7:4]);
      nib(rs, b[3:0]);
    end else begin
      nib(1'b0, b[7:4]);
    end
    idle(2);
  endtask

  task automatic send(input bit rs, input logic [7:0] b);
    bit four;
    four = m_mode4;
    m_apply(rs, b);
    send_raw(rs, b, four);
  endtask

  task automatic rd(input logic [6:0] a, output logic [7:0] v);
    @(posedge clk); #1 rd_addr = a;
    @(posedge clk);
    @(negedge clk);
    v = rd_data;
  endtask

  task automatic check_state(input string t);
    chk({t, ".mode_4bit"}, mode_4bit, m_mode4);
    chk({t, ".two_line"}, two_line, m_two);
    chk({t, ".display_on"}, display_on, m_disp);
    chk({t, ".addr_counter"}, addr_counter, m_ac);
    chk({t, ".protocol_err"}, protocol_err, m_err);
    chk({t, ".busy"}, busy, 0);
    chk({t, ".pending"}, expq.size(), 0);
  endtask

  task automatic check_mem(input string t);
    logic [7:0] v;
    for (int i = 0; i < 80; i++) begin
      rd(7'(i), v);
      chk($sformatf("%s.ddram[%0d]", t, i), v, m_mem[i]);
    end
    rd(7'd80, v);
    chk({t, ".rd80"}, v, 8'h20);
    rd(7'd127, v);
    chk({t, ".rd127"}, v, 8'h20);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; enable_in = 1'b0;
    repeat (3) @(posedge clk);
    m_reset();
    @(negedge clk);
    chk("rst.cmd_valid", cmd_valid, 0);
    chk("rst.char_valid", char_valid, 0);
    chk("rst.byte_out", byte_out, 0);
    chk("rst.addr_counter", addr_counter, 0);
    chk("rst.mode_4bit", mode_4bit, 0);
    chk("rst.two_line", two_line, 0);
    chk("rst.display_on", display_on, 0);
    chk("rst.protocol_err", protocol_err, 0);
    chk("rst.busy", busy, 1);
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic init_two_line();
    idle(85);
    send(0, 8'h30); send(0, 8'h30); send(0, 8'h30);
    send(0, 8'h20);
    send(0, 8'h28); send(0, 8'h0C); send(0, 8'h01);
    idle(85);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] v;
    int n;
    rst = 1'b1; rs_in = 1'b0; enable_in = 1'b0;
    data_in = 4'h0; rd_addr = 7'd0;
    m_reset();

    // power-up init and greeting
    do_reset();
    init_two_line();
    send(0, 8'h06);
    send(1, "H"); send(1, "E"); send(1, "L");
    send(1, "L"); send(1, "O"); send(1, "!");
    check_state("t1");
    chk("t1.ac_lit", addr_counter, 7'h06);
    chk("t1.mode_lit", mode_4bit, 1);
    rd(7'd0, v); chk("t1.ddram0_lit", v, "H");
    rd(7'd5, v); chk("t1.ddram5_lit", v, "!");
    rd(7'd6, v); chk("t1.ddram6_lit", v, 8'h20);
    check_mem("t1");

    // line-1 end wraps to line 2
    send(0, 8'hA7);
    send(1, "A"); send(1, "B");
    chk("t2.ac_lit", addr_counter, 7'h41);
    rd(7'd39, v); chk("t2.ddram39_lit", v, "A");
    rd(7'd40, v); chk("t2.ddram40_lit", v, "B");
    check_state("t2");

    // low-nibble timeout
    nib(1, 4'h4);
    idle(4000);
    chk("t4.err_early", protocol_err, 0);
    idle(200);
    m_err = 1;
    chk("t4.err_lit", protocol_err, 1);
    send(1, "A");
    rd(7'd41, v); chk("t4.ddram41_lit", v, "A");
    check_state("t4");
    check_mem("t4");

    // char during clear fill is dropped
    do_reset();
    init_two_line();
    chk("t3.err_before", protocol_err, 0);
    send(0, 8'h01);
    idle(6);
    send_raw(1, "X", 1'b1);
    m_err = 1;
    idle(85);
    chk("t3.err_lit", protocol_err, 1);
    check_state("t3");
    check_mem("t3");

    // one-line decrement/increment wrap, out-of-range char
    do_reset();
    idle(85);
    send(0, 8'h20);
    send(0, 8'h0F);
    send(0, 8'h04);
    send(1, "Z");
    chk("t5.ac_lit", addr_counter, 7'h4F);
    rd(7'd0, v); chk("t5.ddram0_lit", v, "Z");
    check_state("t5a");
    send(0, 8'h06);
    send(0, 8'hCF);
    send(1, "Y");
    chk("t5.ac_wrap_lit", addr_counter, 7'h00);
    send(0, 8'hD0);
    send(1, "Q");
    chk("t5.err_lit", protocol_err, 1);
    check_state("t5b");
    check_mem("t5");

    // reset between nibbles, then an 8-bit-mode edge
    nib(0, 4'h3);
    do_reset();
    idle(90);
    m_apply(0, 8'h20);
    @(posedge clk); #1;
    rs_in = 1'b0; data_in = 4'h2; enable_in = 1'b1;
    repeat (4) @(posedge clk);
    #1 enable_in = 1'b0;
    n = 0;
    while (n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (cmd_valid) break;
    end
    chk("t6.latency", n, 3);
    chk("t6.byte_lit", byte_out, 8'h20);
    idle(4);
    chk("t6.mode_lit", mode_4bit, 1);
    check_state("t6");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
